// File: rtl/lcd_pkg.sv
// lcd_pkg: FSM states, panel command bytes and the power-up command table.
package lcd_pkg;
  typedef enum logic [2:0] {RST_LOW, RST_WAIT, INIT, CURSOR, READY, PIX_HI, PIX_LO} state_t;

  localparam logic [7:0] SLPOUT = 8'h11;
  localparam logic [7:0] COLMOD = 8'h3A;
  localparam logic [7:0] MADCTL = 8'h36;
  localparam logic [7:0] DISPON = 8'h29;
  localparam logic [7:0] CASET  = 8'h2A;
  localparam logic [7:0] RASET  = 8'h2B;
  localparam logic [7:0] RAMWR  = 8'h2C;

  typedef struct packed {
    logic       is_data;
    logic [7:0] byte_val;
    logic       wait_after;
  } init_entry_t;

  localparam int INIT_LEN   = 6;
  localparam int CURSOR_LEN = 11;

  localparam init_entry_t INIT_TBL [INIT_LEN] = '{
    '{1'b0, SLPOUT, 1'b1},
    '{1'b0, COLMOD, 1'b0},
    '{1'b1, 8'h55,  1'b0},
    '{1'b0, MADCTL, 1'b0},
    '{1'b1, 8'h60,  1'b0},
    '{1'b0, DISPON, 1'b0}
  };

  // Full-panel window: CASET 0..xmax, RASET 0..ymax, then RAMWR.
  function automatic logic [7:0] cursor_byte(input logic [3:0] i, input logic [15:0] xmax, input logic [15:0] ymax);
    return i == 4'd0 ? CASET : i == 4'd3 ? xmax[15:8] : i == 4'd4 ? xmax[7:0] :
           i == 4'd5 ? RASET : i == 4'd8 ? ymax[15:8] : i == 4'd9 ? ymax[7:0] :
           i == 4'd10 ? RAMWR : 8'h00;
  endfunction

  function automatic logic cursor_is_data(input logic [3:0] i);
    return !(i == 4'd0 || i == 4'd5 || i == 4'd10);
  endfunction
endpackage

// File: rtl/lcd_byte_tx.sv
// lcd_byte_tx: one parallel-bus write, write_edge low then high for CLK_DIV clocks each.
module lcd_byte_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start,
  input  logic       is_data,
  input  logic [7:0] byte_val,
  output logic       done,
  output logic       cmd_data,
  output logic       write_edge,
  output logic [7:0] dout
);
  logic       active;
  logic [4:0] cnt;

  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      active   <= 1'b0;
      cnt      <= '0;
      cmd_data <= 1'b0;
      dout     <= '0;
    end else if (start) begin
      active   <= 1'b1;
      cnt      <= '0;
      cmd_data <= is_data;
      dout     <= byte_val;
    end else if (active) begin
      active <= !done;
      cnt    <= cnt + 5'd1;
    end

  always_comb begin
    done       = active && cnt == 5'(2 * CLK_DIV - 1);
    write_edge = !(active && cnt < 5'(CLK_DIV));
  end
endmodule

// File: rtl/lcd_pixel_writer.sv
// lcd_pixel_writer: panel reset/init, window setup and RGB565 pixel writes over an 8-bit LCD bus.
module lcd_pixel_writer
  import lcd_pkg::*;
#(
  parameter int          CLK_DIV      = 2,
  parameter logic [15:0] RESET_CYCLES = 16'd50000,
  parameter logic [19:0] WAKE_CYCLES  = 20'd600000,
  parameter int          WIDTH        = 320,
  parameter int          HEIGHT       = 240
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pix_clk,
  input  logic [15:0] pix_data,
  input  logic        reset_cursor,
  output logic        busy,
  output logic        nreset,
  output logic        cmd_data,
  output logic        write_edge,
  output logic [7:0]  dout
);
  state_t      state, state_n;
  logic [3:0]  idx, idx_n;
  logic [19:0] cnt, cnt_n;
  logic        wt, wt_n, pend, pend_n, launch, done, tx_data;
  logic [7:0]  tx_byte, pix_lo;

  lcd_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk_i(clk_i), .rst_ni(rst_ni), .start(launch), .is_data(tx_data), .byte_val(tx_byte),
    .done(done), .cmd_data(cmd_data), .write_edge(write_edge), .dout(dout)
  );

  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      state  <= RST_LOW;
      idx    <= '0;
      cnt    <= 20'(RESET_CYCLES);
      wt     <= 1'b0;
      pend   <= 1'b0;
      busy   <= 1'b1;
      pix_lo <= '0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      wt     <= wt_n;
      pend   <= pend_n;
      busy   <= state_n != READY;
      pix_lo <= state == READY && pix_clk ? pix_data[7:0] : pix_lo;
    end

  // A byte is launched in the same cycle the FSM moves onto its slot, so bytes run back to back.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt == '0 ? cnt : cnt - 20'd1;
    wt_n    = wt;
    launch  = 1'b0;
    pend_n  = pend || (reset_cursor && (state == PIX_HI || state == PIX_LO));
    case (state)
      RST_LOW:
        if (cnt == '0) begin
          state_n = RST_WAIT;
          cnt_n   = WAKE_CYCLES;
        end
      RST_WAIT:
        if (cnt == '0) begin
          state_n = INIT;
          idx_n   = '0;
          launch  = 1'b1;
        end
      INIT:
        if (done && INIT_TBL[idx[2:0]].wait_after) begin
          wt_n  = 1'b1;
          cnt_n = WAKE_CYCLES;
        end else if (wt ? cnt == '0 : done) begin
          wt_n    = 1'b0;
          launch  = 1'b1;
          state_n = idx == 4'(INIT_LEN - 1) ? CURSOR : INIT;
          idx_n   = idx == 4'(INIT_LEN - 1) ? 4'd0 : idx + 4'd1;
        end
      CURSOR:
        if (done) begin
          launch  = idx != 4'(CURSOR_LEN - 1);
          state_n = idx == 4'(CURSOR_LEN - 1) ? READY : CURSOR;
          idx_n   = idx == 4'(CURSOR_LEN - 1) ? 4'd0 : idx + 4'd1;
        end
      READY:
        if (reset_cursor || pix_clk) begin
          state_n = reset_cursor ? CURSOR : PIX_HI;
          idx_n   = '0;
          launch  = 1'b1;
        end
      PIX_HI:
        if (done) begin
          state_n = PIX_LO;
          launch  = 1'b1;
        end
      PIX_LO:
        if (done) begin
          state_n = pend_n ? CURSOR : READY;
          idx_n   = '0;
          launch  = pend_n;
        end
      default: state_n = RST_LOW;
    endcase
    if (state_n == CURSOR && state != CURSOR) pend_n = 1'b0;
  end

  always_comb begin
    nreset  = state != RST_LOW;
    tx_byte = state_n == INIT   ? INIT_TBL[idx_n[2:0]].byte_val :
              state_n == CURSOR ? cursor_byte(idx_n, 16'(WIDTH - 1), 16'(HEIGHT - 1)) :
              state_n == PIX_HI ? pix_data[15:8] : pix_lo;
    tx_data = state_n == INIT   ? INIT_TBL[idx_n[2:0]].is_data :
              state_n == CURSOR ? cursor_is_data(idx_n) : 1'b1;
  end
endmodule

// File: tb/tb_lcd_pixel_writer.sv
// tb_lcd_pixel_writer: byte-stream and busy-timing model of the LCD writer, directed plus random pixels.
module tb_lcd_pixel_writer;
  localparam int CD = 2, W = 320, H = 240;
  localparam int PIX_T = 2 * 2 * CD, CUR_T = 11 * 2 * CD;

  logic        clk = 1'b0, rst_ni = 1'b0, pix_clk = 1'b0, reset_cursor = 1'b0;
  logic [15:0] pix_data = '0;
  logic        busy, nreset, cmd_data, write_edge;
  logic [7:0]  dout;

  int   checks = 0, errors = 0, cyc = 0, free_at = 0, pix_free = 0, low_cnt = 0;
  bit   pend = 0, track = 0, mon_en = 0;
  logic we_prev = 1'b1;
  logic [8:0] exp_q[$], log_q[$];

  lcd_pixel_writer #(
    .CLK_DIV(CD), .RESET_CYCLES(16'd4), .WAKE_CYCLES(20'd3), .WIDTH(W), .HEIGHT(H)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .pix_clk(pix_clk), .pix_data(pix_data), .reset_cursor(reset_cursor),
    .busy(busy), .nreset(nreset), .cmd_data(cmd_data), .write_edge(write_edge), .dout(dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, want, cyc);
    end
  endtask

  task automatic push_cursor();
    logic [15:0] xm, ym;
    xm = 16'(W - 1);
    ym = 16'(H - 1);
    exp_q.push_back({1'b0, 8'h2A}); exp_q.push_back(9'h100); exp_q.push_back(9'h100);
    exp_q.push_back({1'b1, xm[15:8]}); exp_q.push_back({1'b1, xm[7:0]});
    exp_q.push_back({1'b0, 8'h2B}); exp_q.push_back(9'h100); exp_q.push_back(9'h100);
    exp_q.push_back({1'b1, ym[15:8]}); exp_q.push_back({1'b1, ym[7:0]});
    exp_q.push_back({1'b0, 8'h2C});
  endtask

  task automatic push_init();
    exp_q.push_back(9'h011); exp_q.push_back(9'h03A); exp_q.push_back(9'h155);
    exp_q.push_back(9'h036); exp_q.push_back(9'h160); exp_q.push_back(9'h029);
    push_cursor();
  endtask

  // Bus monitor and per-cycle busy check against the model.
  always @(negedge clk) begin
    if (mon_en && write_edge === 1'b1 && we_prev === 1'b0) begin
      log_q.push_back({cmd_data, dout});
      chk("write_edge_low_len", low_cnt, CD);
      if (exp_q.size() == 0) chk("unexpected_byte", {cmd_data, dout}, 9'h1FF ^ {cmd_data, dout});
      else chk("bus_byte", {cmd_data, dout}, exp_q.pop_front());
      low_cnt = 0;
    end else if (write_edge === 1'b0) low_cnt++;
    we_prev = write_edge;
    if (track) chk("busy", busy, 32'(cyc < free_at));
  end

  // Drives one cycle of inputs and applies the spec's acceptance rules to the model.
  task automatic pulse(input logic p, input logic r, input logic [15:0] d);
    int k;
    @(negedge clk);
    pix_clk = p; reset_cursor = r; pix_data = d;
    k = cyc + 1;
    @(posedge clk);
    #1;
    if (r) begin
      if (k - 1 >= free_at) begin
        push_cursor(); free_at = k + CUR_T; pend = 0;
      end else if (k - 1 < pix_free && !pend) begin
        push_cursor(); free_at += CUR_T; pend = 1;
      end
    end else if (p && k - 1 >= free_at) begin
      exp_q.push_back({1'b1, d[15:8]}); exp_q.push_back({1'b1, d[7:0]});
      free_at = k + PIX_T; pix_free = k + PIX_T; pend = 0;
    end
    @(negedge clk);
    pix_clk = 1'b0; reset_cursor = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cyc < free_at && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
  endtask

  task automatic do_init();
    int n;
    exp_q.delete(); log_q.delete(); push_init();
    low_cnt = 0; mon_en = 1;
    chk("rst_nreset", nreset, 0); chk("rst_write_edge", write_edge, 1);
    chk("rst_busy", busy, 1); chk("rst_dout", dout, 0); chk("rst_cmd_data", cmd_data, 0);
    rst_ni = 1'b1;
    n = 0;
    do begin @(negedge clk); if (nreset !== 1'b1) n++; end while (nreset !== 1'b1 && n < 100);
    chk("nreset_low_cycles", n, 4);
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    chk("init_busy_fall", busy, 0);
    chk("init_bytes_left", exp_q.size(), 0);
    chk("init_byte_count", log_q.size(), 17);
    chk("init_first", log_q[0], 9'h011);
    chk("caset_xmax_hi", log_q[9], 9'h101);
    chk("caset_xmax_lo", log_q[10], 9'h13F);
    chk("raset_ymax_lo", log_q[15], 9'h1EF);
    chk("init_last", log_q[16], 9'h02C);
    free_at = cyc; pix_free = 0; pend = 0; track = 1;
  endtask

  initial begin
    int n, base;
    repeat (3) @(negedge clk);
    do_init();

    base = log_q.size();
    pulse(1'b1, 1'b0, 16'hF81F);
    n = 0;
    while (busy === 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("pixel_busy_len", n, 8);
    wait_idle();
    chk("pixel_count", log_q.size() - base, 2);
    chk("pixel_hi", log_q[base], 9'h1F8);
    chk("pixel_lo", log_q[base + 1], 9'h11F);

    base = log_q.size();
    pulse(1'b1, 1'b0, 16'hABCD);
    pulse(1'b1, 1'b0, 16'h1234);
    wait_idle();
    chk("dropped_count", log_q.size() - base, 2);
    chk("dropped_hi", log_q[base], 9'h1AB);
    chk("dropped_lo", log_q[base + 1], 9'h1CD);

    base = log_q.size();
    pulse(1'b1, 1'b0, 16'h07E0);
    pulse(1'b0, 1'b1, 16'h0000);
    wait_idle();
    chk("deferred_count", log_q.size() - base, 13);
    chk("deferred_hi", log_q[base], 9'h107);
    chk("deferred_lo", log_q[base + 1], 9'h1E0);
    chk("deferred_caset", log_q[base + 2], 9'h02A);
    chk("deferred_ramwr", log_q[base + 12], 9'h02C);

    base = log_q.size();
    pulse(1'b1, 1'b1, 16'hBEEF);
    wait_idle();
    chk("simul_count", log_q.size() - base, 11);
    chk("simul_first", log_q[base], 9'h02A);

    for (int i = 0; i < 1500; i++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      pulse($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, 16'($urandom));
    end
    wait_idle();
    chk("random_bytes_left", exp_q.size(), 0);

    pulse(1'b1, 1'b0, 16'h5A5A);
    repeat (4) @(negedge clk);
    chk("pix_lo_phase_low", write_edge, 0);
    track = 0; mon_en = 0; rst_ni = 1'b0;
    @(negedge clk);
    chk("midrst_write_edge", write_edge, 1);
    chk("midrst_nreset", nreset, 0);
    chk("midrst_busy", busy, 1);
    chk("midrst_dout", dout, 0);
    @(negedge clk);
    do_init();
    wait_idle();
    chk("final_bytes_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_pixel_writer.md
Name: lcd_pixel_writer

Overview:
- Consumes the per-pixel stream that the TIA video engine produces while racing the beam: a 1-cycle `pix_clk` pulse with `pix_data`, plus a `reset_cursor` pulse at frame start.
- Answers with `busy`.
- Drives an 8-bit parallel ST7789/ILI9341-class LCD bus (`nreset`, `cmd_data`, `write_edge`, `dout`).
- Owns the panel reset, the init sequence, the window/cursor commands and the two-byte RGB565 transfers.

Parameters:
- CLK_DIV, 2, clk_i cycles per `write_edge` phase (low phase and high phase each); 1..15.
- RESET_CYCLES, 16'd50000, clk_i cycles `nreset` is held low after rst_ni release.
- WAKE_CYCLES, 20'd600000, delay after SLPOUT and after the reset release.
- WIDTH, 320, panel columns.
- HEIGHT, 240, panel rows.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  synchronous active-low reset.
- pix_clk  input  1  1-cycle pixel strobe; valid only when busy=0.
- pix_data  input  16  RGB565 pixel, sampled with pix_clk.
- reset_cursor  input  1  1-cycle pulse: restart the panel write window at (0,0).
- busy  output  1  high while unable to accept pix_clk.
- nreset  output  1  panel reset, active low.
- cmd_data  output  1  0=command byte, 1=data byte.
- write_edge  output  1  write strobe; panel latches dout/cmd_data on its rising edge.
- dout  output  8  panel data bus.

Behaviour:
- Reset is synchronous and active-low: one clock `clk_i`, reset `rst_ni`. While rst_ni=0:
  - nreset=0, write_edge=1, cmd_data=0, dout=0, busy=1.
  - FSM in RST_LOW; the pending-cursor flag is cleared.
  - Reset asserted mid-transfer aborts at the next edge; write_edge returns high immediately.
- Byte transmit (sub-module), from start pulse:
  - dout/cmd_data load on the start edge; write_edge=0 for CLK_DIV cycles, then 1 for CLK_DIV cycles.
  - done pulses on the last high cycle, so a byte takes 2*CLK_DIV cycles.
  - dout/cmd_data are held stable across the whole byte and are not changed until the next start.
- FSM states:
  - RST_LOW: count RESET_CYCLES, then set nreset=1 → RST_WAIT.
  - RST_WAIT: count WAKE_CYCLES → INIT.
  - INIT: walk the init table in order. Each entry is {is_data, byte, wait_after}; if wait_after=1, wait WAKE_CYCLES after the byte. Table order:
    - cmd 0x11 (SLPOUT, wait)
    - cmd 0x3A, data 0x55 (16-bit colour)
    - cmd 0x36, data 0x60 (landscape MADCTL)
    - cmd 0x29 (DISPON)
    - then go to CURSOR.
  - CURSOR: send 11 bytes in order:
    - cmd 0x2A, data 0x00, 0x00, (WIDTH-1)>>8, (WIDTH-1)&0xFF
    - cmd 0x2B, data 0x00, 0x00, (HEIGHT-1)>>8, (HEIGHT-1)&0xFF
    - cmd 0x2C
    - then → READY.
  - READY: busy=0.
    - On pix_clk: latch pix_data, go to PIX_HI.
    - On reset_cursor: go to CURSOR. If both arrive in the same cycle, reset_cursor wins and the pixel is dropped.
  - PIX_HI: send data pix_data[15:8] → PIX_LO.
  - PIX_LO: send data pix_data[7:0] → READY, or → CURSOR if the pending flag is set (flag cleared on entry).
- busy:
  - Registered; equals (state != READY).
  - Rises the cycle after an accepted pix_clk. The producer must leave at least one cycle between pulses.
  - Falls the cycle after the final byte's done.
- pix_clk while busy=1: ignored, no state change.
- reset_cursor while busy=1:
  - Sets the pending flag, which is serviced after the current pixel.
  - During RST_LOW, RST_WAIT, INIT and CURSOR it is discarded, since CURSOR already homes the window.
- Counters:
  - The delay counter is 20-bit, loads on state entry and decrements to 0. A value of 0 means a 1-cycle wait.
  - The init/cursor index wraps nowhere; the index past the final entry exits the state.

Decomposition:
- Package lcd_pkg:
  - state enum (RST_LOW, RST_WAIT, INIT, CURSOR, READY, PIX_HI, PIX_LO);
  - LCD command constants (SLPOUT 0x11, COLMOD 0x3A, MADCTL 0x36, DISPON 0x29, CASET 0x2A, RASET 0x2B, RAMWR 0x2C);
  - init-table entry struct and table constant.
- Sub-module lcd_byte_tx:
  - inputs start, is_data, byte;
  - outputs done, cmd_data, write_edge, dout;
  - parameter CLK_DIV.

Test Plan:
- Bench parameters: CLK_DIV=2, RESET_CYCLES=4, WAKE_CYCLES=3, WIDTH=320, HEIGHT=240.
- Reset sequence:
  - Stimulus: release rst_ni.
  - Response: nreset stays 0 for 4 cycles, then 1. The logged write_edge rising edges show exactly {0:11}, {0:3A}, {1:55}, {0:36}, {1:60}, {0:29}, {0:2A}, {1:00}, {1:00}, {1:01}, {1:3F}, {0:2B}, {1:00}, {1:00}, {1:00}, {1:EF}, {0:2C}. busy=1 throughout, then busy=0.
- Single pixel:
  - Stimulus: in READY, pix_clk with pix_data=0xF81F.
  - Response: busy=1 the next cycle. Two data bytes 0xF8 then 0x1F are latched, each with write_edge low 2 cycles / high 2 cycles. busy=0 exactly 9 cycles after the pulse.
- Dropped pixel:
  - Stimulus: pix_clk (0x1234) issued 2 cycles into a transfer of 0xABCD.
  - Response: only 0xAB, 0xCD appear on the bus; no 0x12/0x34.
- Deferred cursor:
  - Stimulus: reset_cursor during PIX_HI of 0x07E0.
  - Response: bytes 0x07, 0xE0, then the 11-byte CURSOR sequence ending with cmd 0x2C; busy stays 1 until it completes.
- Simultaneous events:
  - Stimulus: in READY, pix_clk and reset_cursor in the same cycle.
  - Response: the CURSOR sequence only; no pixel bytes.
- Mid-operation reset:
  - Stimulus: rst_ni=0 during write_edge low of PIX_LO.
  - Response: next cycle write_edge=1, nreset=0, busy=1, dout=0; the full init sequence repeats after release.
